// File: rtl/fft_bin_quantizer_if.sv
// Bin-sample bus for fft_bin_quantizer: complex bin samples in, quantized
// display levels and frame-peak index out.
interface fft_bin_quantizer_if #(
    parameter int WORD_WIDTH = 16,
    parameter int FFT_SIZE   = 128
);
    localparam int IDXW = $clog2(FFT_SIZE / 2);

    logic                    in_valid;
    logic [IDXW-1:0]         in_idx;
    logic [2*WORD_WIDTH-1:0] in_data;
    logic                    decay_en;
    logic                    out_valid;
    logic [IDXW-1:0]         out_idx;
    logic [3:0]              out_level;
    logic                    out_frame_done;
    logic [IDXW-1:0]         frame_peak_idx;

    modport master (
        output in_valid, in_idx, in_data, decay_en,
        input  out_valid, out_idx, out_level, out_frame_done, frame_peak_idx
    );

    modport slave (
        input  in_valid, in_idx, in_data, decay_en,
        output out_valid, out_idx, out_level, out_frame_done, frame_peak_idx
    );
endinterface

// File: rtl/fft_bin_quantizer.sv
// Four-stage FFT bin quantizer: |z| approximation, log2 display level,
// optional per-bin peak hold with decay, and per-frame peak-bin tracking.
module fft_bin_quantizer #(
    parameter int WORD_WIDTH  = 16,
    parameter int FFT_SIZE    = 128,
    parameter int FLOOR_SHIFT = 2,
    parameter int DECAY_STEP  = 1
) (
    input  logic clk,
    input  logic reset,
    fft_bin_quantizer_if.slave bus
);
    localparam int NUM_BINS = FFT_SIZE / 2;
    localparam int IDXW     = $clog2(NUM_BINS);
    localparam int MW       = WORD_WIDTH + 1;
    localparam int MAGW     = 18;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_BINS - 1);

    // Stage registers
    logic                s1_valid_reg, s2_valid_reg, s3_valid_reg;
    logic [IDXW-1:0]     s1_idx_reg, s2_idx_reg, s3_idx_reg;
    logic                s1_decay_reg, s2_decay_reg, s3_decay_reg;
    logic [MW-1:0]       s1_re_reg, s1_im_reg;
    logic [MW-1:0]       s2_mx_reg, s2_mn_reg;
    logic [MAGW-1:0]     s3_mag_reg;

    // Hold storage and read path
    logic [3:0]          hold_mem [NUM_BINS];
    logic [NUM_BINS-1:0] valid_vec_reg;
    logic [3:0]          hold_rd_reg;
    logic                hold_ok_reg;
    logic                fwd_hit_reg;
    logic [3:0]          fwd_val_reg;

    // Output and frame tracking
    logic                out_valid_reg;
    logic [IDXW-1:0]     out_idx_reg;
    logic [3:0]          out_level_reg;
    logic                out_frame_done_reg;
    logic [IDXW-1:0]     frame_peak_idx_reg;
    logic [3:0]          run_lvl_reg;
    logic [IDXW-1:0]     run_idx_reg;

    logic [MW-1:0]       comp_abs [2];
    logic [MAGW-1:0]     mag_next;
    logic [3:0]          hold_eff;
    logic [3:0]          level_next;
    logic [3:0]          cand_lvl;
    logic [IDXW-1:0]     cand_idx;
    int                  msb;
    int                  lvl_int;
    int                  decay_int;
    int                  level_int;

    // Index 0 is the imaginary part, index 1 the real part; one extra bit keeps |-2^(W-1)|.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            logic [WORD_WIDTH-1:0] comp;
            logic [MW-1:0]         comp_ext;
            assign comp        = bus.in_data[gi*WORD_WIDTH +: WORD_WIDTH];
            assign comp_ext    = {comp[WORD_WIDTH-1], comp};
            assign comp_abs[gi] = comp[WORD_WIDTH-1] ? (~comp_ext + MW'(1)) : comp_ext;
        end
    endgenerate

    assign mag_next = MAGW'(s2_mx_reg) + MAGW'(s2_mn_reg >> 2) + MAGW'(s2_mn_reg >> 3);

    always_comb begin
        msb = 0;
        for (int i = 0; i < MAGW; i++) begin
            if (s3_mag_reg[i]) msb = i;
        end
        lvl_int = (s3_mag_reg == '0) ? 0 : msb + 1 - FLOOR_SHIFT;
        if (lvl_int < 0)  lvl_int = 0;
        if (lvl_int > 15) lvl_int = 15;

        // The previous sample's write is not yet visible in the registered read.
        hold_eff = fwd_hit_reg ? fwd_val_reg : (hold_ok_reg ? hold_rd_reg : 4'd0);
        decay_int = int'(hold_eff) - DECAY_STEP;
        if (decay_int < 0) decay_int = 0;
        level_int  = (s3_decay_reg && decay_int > lvl_int) ? decay_int : lvl_int;
        level_next = 4'(level_int);

        cand_lvl = run_lvl_reg;
        cand_idx = run_idx_reg;
        if (s3_idx_reg == '0) begin
            cand_lvl = level_next;
            cand_idx = '0;
        end else if (level_next > run_lvl_reg ||
                     (level_next == run_lvl_reg && s3_idx_reg < run_idx_reg)) begin
            cand_lvl = level_next;
            cand_idx = s3_idx_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_reg       <= 1'b0;
            s2_valid_reg       <= 1'b0;
            s3_valid_reg       <= 1'b0;
            s1_idx_reg         <= '0;
            s2_idx_reg         <= '0;
            s3_idx_reg         <= '0;
            s1_decay_reg       <= 1'b0;
            s2_decay_reg       <= 1'b0;
            s3_decay_reg       <= 1'b0;
            s1_re_reg          <= '0;
            s1_im_reg          <= '0;
            s2_mx_reg          <= '0;
            s2_mn_reg          <= '0;
            s3_mag_reg         <= '0;
            valid_vec_reg      <= '0;
            hold_ok_reg        <= 1'b0;
            fwd_hit_reg        <= 1'b0;
            fwd_val_reg        <= '0;
            out_valid_reg      <= 1'b0;
            out_idx_reg        <= '0;
            out_level_reg      <= '0;
            out_frame_done_reg <= 1'b0;
            frame_peak_idx_reg <= '0;
            run_lvl_reg        <= '0;
            run_idx_reg        <= '0;
        end else begin
            s1_valid_reg <= bus.in_valid;
            s1_idx_reg   <= bus.in_idx;
            s1_decay_reg <= bus.decay_en;
            s1_re_reg    <= comp_abs[1];
            s1_im_reg    <= comp_abs[0];

            s2_valid_reg <= s1_valid_reg;
            s2_idx_reg   <= s1_idx_reg;
            s2_decay_reg <= s1_decay_reg;
            s2_mx_reg    <= (s1_re_reg >= s1_im_reg) ? s1_re_reg : s1_im_reg;
            s2_mn_reg    <= (s1_re_reg >= s1_im_reg) ? s1_im_reg : s1_re_reg;

            s3_valid_reg <= s2_valid_reg;
            s3_idx_reg   <= s2_idx_reg;
            s3_decay_reg <= s2_decay_reg;
            s3_mag_reg   <= mag_next;
            hold_ok_reg  <= valid_vec_reg[s2_idx_reg];
            fwd_hit_reg  <= s3_valid_reg && (s3_idx_reg == s2_idx_reg);
            fwd_val_reg  <= level_next;

            out_valid_reg      <= s3_valid_reg;
            out_idx_reg        <= s3_idx_reg;
            out_level_reg      <= level_next;
            out_frame_done_reg <= s3_valid_reg && (s3_idx_reg == LAST_IDX);

            if (s3_valid_reg) begin
                valid_vec_reg[s3_idx_reg] <= 1'b1;
                run_lvl_reg <= cand_lvl;
                run_idx_reg <= cand_idx;
                if (s3_idx_reg == LAST_IDX) frame_peak_idx_reg <= cand_idx;
            end
        end
    end

    // Hold memory: written with the emitted level, read one stage ahead.
    always_ff @(posedge clk) begin
        if (s3_valid_reg) hold_mem[s3_idx_reg] <= level_next;
        hold_rd_reg <= hold_mem[s2_idx_reg];
    end

    assign bus.out_valid      = out_valid_reg;
    assign bus.out_idx        = out_idx_reg;
    assign bus.out_level      = out_level_reg;
    assign bus.out_frame_done = out_frame_done_reg;
    assign bus.frame_peak_idx = frame_peak_idx_reg;
endmodule

// File: doc/fft_bin_quantizer.md
FFT_BIN_QUANTIZER -- requirements
Module: fft_bin_quantizer

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 16: width of each signed real/imag component.
REQ-002 SHALL have parameter FFT_SIZE, default 128: FFT length; NUM_BINS = FFT_SIZE/2, IDXW = clog2(NUM_BINS).
REQ-003 SHALL have parameter FLOOR_SHIFT, default 2: log-scale floor offset.
REQ-004 SHALL have parameter DECAY_STEP, default 1: per-frame peak-hold decrement, in levels.
REQ-005 SHALL have port clk  input  1  sole clock, all logic on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  bin sample strobe, one bin per cycle max, no backpressure.
REQ-008 SHALL have port in_idx  input  IDXW  bin index of the sample.
REQ-009 SHALL have port in_data  input  2*WORD_WIDTH  {real[31:16], imag[15:0]}, two's complement.
REQ-010 SHALL have port decay_en  input  1  1 = peak-hold with decay, 0 = raw level passthrough.
REQ-011 SHALL have port out_valid  output  1  quantized bin strobe.
REQ-012 SHALL have port out_idx  output  IDXW  bin index matching out_level.
REQ-013 SHALL have port out_level  output  4  display level 0..15.
REQ-014 SHALL have port out_frame_done  output  1  one-cycle pulse with the output of bin NUM_BINS-1.
REQ-015 SHALL have port frame_peak_idx  output  IDXW  bin holding max out_level in the last completed frame.

Function
REQ-016 SHALL be a 4-stage pipeline: in_valid at cycle N -> out_valid at cycle N+4, fixed, with in_idx carried alongside.
REQ-017 Stage 1 SHALL compute |re|, |im| at WORD_WIDTH+1 bits so -32768 maps to 32768 without overflow.
REQ-018 Stage 2 SHALL compute mx = max, mn = min of the two magnitudes.
REQ-019 Stage 3 SHALL compute mag = mx + (mn>>2) + (mn>>3), 18 bits unsigned, truncating shifts, no saturation.
REQ-020 Stage 4 SHALL compute lvl: mag==0 -> 0; else p = floor(log2(mag)), lvl = clamp(p+1-FLOOR_SHIFT, 0, 15).
REQ-021 With decay_en=1, SHALL output max(lvl, hold[idx] - DECAY_STEP, floored at 0), then write that value to hold[idx].
REQ-022 With decay_en=0, SHALL output lvl, write lvl to hold[idx] regardless.
REQ-023 Hold storage SHALL be NUM_BINS x 4 bits with a NUM_BINS-bit valid vector; an entry with a clear valid bit reads as 0.
REQ-024 Back-to-back samples with the same idx SHALL forward the just-written hold value (no stale read).
REQ-025 Bubbles (in_valid=0) SHALL propagate as out_valid=0 and leave hold/valid state unchanged.
REQ-026 out_frame_done SHALL be 1 exactly on the cycle out_valid=1 with out_idx = NUM_BINS-1.
REQ-027 A running frame max SHALL track (level, idx); ties keep the lower idx; it restarts on the output of idx 0.
REQ-028 frame_peak_idx SHALL update on the out_frame_done cycle, including that bin's own level, and hold otherwise.
REQ-029 Out-of-order or missing bins SHALL NOT stall or error; quantization is per sample, frame tracking keys only on idx 0 and NUM_BINS-1.

Reset
REQ-030 While reset=0 at a clk edge: out_valid, out_idx, out_level, out_frame_done, frame_peak_idx, all pipeline valids, the valid vector and the running max SHALL be 0.
REQ-031 Reset mid-frame SHALL discard all in-flight samples; no out_valid for samples accepted at or before the reset cycle.
REQ-032 First in_valid accepted on the cycle after reset deasserts SHALL appear 4 cycles later.

Verification
REQ-033 Bench: in_data={16'd1024,16'd0}, decay_en=0 -> 4 cycles later out_level=9 (mag 1024, p=10).
REQ-034 Bench: in_data={16'h8000,16'h8000} -> mag=32768+4096+8192=45056, p=15, out_level=14; in_data=0 -> out_level=0.
REQ-035 Bench: decay_en=1, bin 5 level 12 in frame 1, then level 0 in frames 2..4 -> bin 5 outputs 11, 10, 9.
REQ-036 Bench: same idx on 3 consecutive cycles, decay_en=1, levels 10, 0, 0 -> outputs 10, 9, 8 (forwarding).
REQ-037 Bench: full frame idx 0..63 in consecutive cycles, bins 7 and 20 both level 13, rest lower -> out_frame_done once on idx 63, frame_peak_idx=7.
REQ-038 Bench: reset asserted 2 cycles after a burst starts -> no out_valid from that burst, and next frame's hold reads as 0.
